// File: rtl/mips_store_monitor.sv
// Store-bus monitor for the multicycle MIPS core: logs stores into a FIFO and
// resolves a PASS / FAIL / TIMEOUT verdict from the store stream.
module mips_store_monitor #(
  parameter logic [31:0] PASS_ADDR    = 32'd84,
  parameter logic [31:0] PASS_DATA    = 32'd7,
  parameter logic [31:0] SCRATCH_ADDR = 32'd80,
  parameter int          DEPTH        = 8,
  parameter logic [31:0] TIMEOUT      = 32'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  input  logic        clear,
  input  logic        rd_en,
  output logic        rd_valid,
  output logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic        overflow,
  output logic [15:0] store_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TOUT} state_t;

  state_t      r_state;
  logic [1:0]  r_rst_sync;
  logic [31:0] r_cycles;
  logic [15:0] r_store_count;
  logic        r_pass;
  logic        r_fail;
  logic        r_timeout;
  logic        r_overflow;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [31:0] r_mem_addr [DEPTH];
  logic [31:0] r_mem_data [DEPTH];

  logic        w_active;
  logic        w_empty;
  logic        w_full;
  logic        w_accept;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [31:0] w_cycles_next;

  // Reset asserts asynchronously but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_active      = r_rst_sync[1];
  assign w_empty       = (r_wr_ptr == r_rd_ptr);
  assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_accept      = w_active && !clear && memwrite && (r_state == S_RUN);
  assign w_pop         = w_active && !clear && rd_en && !w_empty;
  // A full FIFO still takes the store when the head is popped in the same cycle.
  assign w_push        = w_accept && (!w_full || w_pop);
  assign w_drop        = w_accept && w_full && !w_pop;
  assign w_cycles_next = r_cycles + 32'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_addr[i] <= '0;
        r_mem_data[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_addr[r_wr_ptr[AW-1:0]] <= dataadr;
      r_mem_data[r_wr_ptr[AW-1:0]] <= writedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_RUN;
      r_cycles      <= '0;
      r_store_count <= '0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_timeout     <= 1'b0;
      r_overflow    <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else if (w_active) begin
      if (clear) begin
        r_state       <= S_RUN;
        r_cycles      <= '0;
        r_store_count <= '0;
        r_pass        <= 1'b0;
        r_fail        <= 1'b0;
        r_timeout     <= 1'b0;
        r_overflow    <= 1'b0;
        r_wr_ptr      <= '0;
        r_rd_ptr      <= '0;
      end else begin
        if (r_state == S_RUN) begin
          r_cycles <= w_cycles_next;
          // A store decided on the timeout cycle overrides the timeout.
          if (memwrite) begin
            if (dataadr == PASS_ADDR && writedata == PASS_DATA) begin
              r_state <= S_PASS;
              r_pass  <= 1'b1;
            end else if (dataadr != SCRATCH_ADDR) begin
              r_state <= S_FAIL;
              r_fail  <= 1'b1;
            end else if (w_cycles_next == TIMEOUT) begin
              r_state   <= S_TOUT;
              r_timeout <= 1'b1;
            end
          end else if (w_cycles_next == TIMEOUT) begin
            r_state   <= S_TOUT;
            r_timeout <= 1'b1;
          end
        end
        if (w_accept && r_store_count != 16'hFFFF)
          r_store_count <= r_store_count + 16'd1;
        if (w_drop)
          r_overflow <= 1'b1;
        if (w_push)
          r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign rd_valid    = !w_empty;
  assign rd_addr     = r_mem_addr[r_rd_ptr[AW-1:0]];
  assign rd_data     = r_mem_data[r_rd_ptr[AW-1:0]];
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_timeout;
  assign overflow    = r_overflow;
  assign store_count = r_store_count;

endmodule

// File: tb/tb_mips_store_monitor.sv
// Directed bench for mips_store_monitor: verdicts, FIFO trace, overflow,
// clear and asynchronous reset. A second instance uses TIMEOUT=20.
module tb_mips_store_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic        clear = 1'b0;
  logic        rd_en = 1'b0;

  logic        rd_valid, pass, fail, timeout, overflow;
  logic [31:0] rd_addr, rd_data;
  logic [15:0] store_count;

  logic        t_rd_valid, t_pass, t_fail, t_timeout, t_overflow;
  logic [31:0] t_rd_addr, t_rd_data;
  logic [15:0] t_store_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_store_monitor #(.DEPTH(8), .TIMEOUT(32'd1000)) u_dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .clear(clear), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .pass(pass), .fail(fail), .timeout(timeout), .overflow(overflow),
    .store_count(store_count)
  );

  mips_store_monitor #(.DEPTH(8), .TIMEOUT(32'd20)) u_dut_t (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .clear(clear), .rd_en(rd_en),
    .rd_valid(t_rd_valid), .rd_addr(t_rd_addr), .rd_data(t_rd_data),
    .pass(t_pass), .fail(t_fail), .timeout(t_timeout), .overflow(t_overflow),
    .store_count(t_store_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=stuck expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_fail", {31'd0, fail}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_count", {16'd0, store_count}, 32'd0);
    check("rst_rd_addr", rd_addr, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);

    // 80<-3 then 84<-7: PASS and trace readback
    do_clear();
    store(32'd80, 32'd3);
    check("t1_pass_early", {31'd0, pass}, 32'd0);
    store(32'd84, 32'd7);
    check("t1_pass", {31'd0, pass}, 32'd1);
    check("t1_fail", {31'd0, fail}, 32'd0);
    check("t1_count", {16'd0, store_count}, 32'd2);
    check("t1_valid0", {31'd0, rd_valid}, 32'd1);
    check("t1_addr0", rd_addr, 32'd80);
    check("t1_data0", rd_data, 32'd3);
    pop();
    check("t1_addr1", rd_addr, 32'd84);
    check("t1_data1", rd_data, 32'd7);
    pop();
    check("t1_empty", {31'd0, rd_valid}, 32'd0);

    // 84<-5 fails; later 84<-7 ignored
    do_clear();
    store(32'd84, 32'd5);
    check("t2_fail", {31'd0, fail}, 32'd1);
    store(32'd84, 32'd7);
    check("t2_pass_ignored", {31'd0, pass}, 32'd0);
    check("t2_count", {16'd0, store_count}, 32'd1);
    check("t2_head_data", rd_data, 32'd5);

    // Timeout on the 20-cycle instance
    do_clear();
    idle(19);
    check("t3_timeout_19", {31'd0, t_timeout}, 32'd0);
    idle(1);
    check("t3_timeout_20", {31'd0, t_timeout}, 32'd1);
    do_clear();
    check("t3_cleared", {31'd0, t_timeout}, 32'd0);
    idle(19);
    store(32'd84, 32'd7);
    check("t3_store_wins_pass", {31'd0, t_pass}, 32'd1);
    check("t3_store_wins_tout", {31'd0, t_timeout}, 32'd0);

    // Nine stores to 80 without reads: overflow
    do_clear();
    for (int i = 0; i < 9; i++) store(32'd80, 32'(i));
    check("t4_overflow", {31'd0, overflow}, 32'd1);
    check("t4_count", {16'd0, store_count}, 32'd9);
    check("t4_run", {30'd0, pass, fail}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_valid%0d", i), {31'd0, rd_valid}, 32'd1);
      check($sformatf("t4_data%0d", i), rd_data, 32'(i));
      pop();
    end
    check("t4_empty", {31'd0, rd_valid}, 32'd0);

    // Same, but the ninth store coincides with a pop
    do_clear();
    for (int i = 0; i < 8; i++) store(32'd80, 32'(i));
    rd_en = 1'b1;
    store(32'd80, 32'd8);
    rd_en = 1'b0;
    check("t4b_overflow", {31'd0, overflow}, 32'd0);
    check("t4b_count", {16'd0, store_count}, 32'd9);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4b_data%0d", i), rd_data, 32'(i + 1));
      pop();
    end
    check("t4b_empty", {31'd0, rd_valid}, 32'd0);

    // Clear beats a same-cycle store in PASS
    do_clear();
    store(32'd84, 32'd7);
    check("t5_pass", {31'd0, pass}, 32'd1);
    clear = 1'b1;
    store(32'd84, 32'd7);
    clear = 1'b0;
    check("t5_pass_cleared", {31'd0, pass}, 32'd0);
    check("t5_count", {16'd0, store_count}, 32'd0);
    check("t5_empty", {31'd0, rd_valid}, 32'd0);
    idle(1);
    check("t5_not_evaluated", {31'd0, pass}, 32'd0);

    // Asynchronous reset mid-fill
    do_clear();
    store(32'd80, 32'd1);
    store(32'd81, 32'd2);
    check("t6_fail_before", {31'd0, fail}, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check("t6_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("t6_fail", {31'd0, fail}, 32'd0);
    check("t6_count", {16'd0, store_count}, 32'd0);
    check("t6_rd_addr", rd_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);
    store(32'd84, 32'd7);
    check("t6_pass_after", {31'd0, pass}, 32'd1);
    check("t6_count_after", {16'd0, store_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_store_monitor.md
# mips_store_monitor

Synthesizable store-bus monitor that sits directly downstream of the multicycle MIPS core and consumes its memory-write bus (memwrite, dataadr, writedata). It logs every store into a small FIFO and resolves a PASS / FAIL / TIMEOUT verdict in hardware, using the rule the team's programs are written against: a store of 7 to address 84 passes; any store to an address other than 80 fails. The block lets FPGA runs self-check without a simulator, and exposes the store trace through a read port.

## Interface
Parameters:
- PASS_ADDR, 32'd84, address of the success store
- PASS_DATA, 32'd7, data value required at PASS_ADDR
- SCRATCH_ADDR, 32'd80, address whose stores are tolerated without a verdict
- DEPTH, 8, FIFO entries (power of two, ≥2)
- TIMEOUT, 32'd1000, RUN cycles allowed before TIMEOUT

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- memwrite  in  1  core store strobe; one store per high cycle
- dataadr  in  32  store byte address
- writedata  in  32  store data
- clear  in  1  synchronous re-arm
- rd_en  in  1  pop request for the FIFO head
- rd_valid  out  1  FIFO non-empty
- rd_addr  out  32  head entry address (first-word fall-through)
- rd_data  out  32  head entry data
- pass  out  1  verdict PASS
- fail  out  1  verdict FAIL
- timeout  out  1  verdict TIMEOUT
- overflow  out  1  sticky: a store was dropped because the FIFO was full
- store_count  out  16  stores accepted in RUN, saturating at 16'hFFFF

## Operation
- FSM states: RUN, PASS, FAIL, TOUT. PASS, FAIL and TOUT are terminal and hold until clear or reset.
- A store is accepted when memwrite=1 and the state is RUN. Stores seen in terminal states are ignored: they are not logged, counted or evaluated.
- Classification of an accepted store, in priority order:
  - dataadr==PASS_ADDR and writedata==PASS_DATA: go to PASS.
  - dataadr==SCRATCH_ADDR: stay in RUN.
  - Anything else, including PASS_ADDR with the wrong data: go to FAIL.
- Cycle counter (32 bits) increments every RUN cycle. RUN goes to TOUT when the counter reaches TIMEOUT with no verdict. If an accepted store occurs in the same cycle, the store's classification wins.
- Every accepted store is pushed as {dataadr, writedata}, including the verdict store. store_count increments and saturates.
- FIFO:
  - A push when full drops the entry and sets overflow. The store is still counted and classified.
  - Push and pop in the same cycle are both performed, including when full; overflow is not set in that case.
  - rd_en when empty is ignored.
  - The FIFO stays readable in terminal states.
- Pointers are log2(DEPTH)+1 bits wide. full when the MSBs differ and the rest are equal; empty when the pointers are equal.
- clear returns the FSM to RUN and zeroes the FIFO pointers, cycle counter, store_count and overflow. clear beats a same-cycle store (the store is ignored) and beats rd_en.

## Timing
- Reset values (asynchronous, on reset=0): state RUN; pass, fail, timeout and overflow = 0; store_count = 0; rd_valid = 0; rd_addr and rd_data = 0 (the FIFO storage array is also cleared).
- All outputs are registered or derived from registers only. There is no combinational path from inputs to outputs.
- Verdict latency: pass, fail or timeout is asserted after the rising edge that samples the deciding store or count. store_count and rd_valid update after that same edge.
- rd_en pops on the edge. The next head appears in the following cycle.
- Reset asserted mid-run aborts immediately. Reset release is synchronized internally with a 2-flop chain. The FSM leaves reset in RUN with the counter at 0.

## Test plan
- Store 80←3 then 84←7, one cycle apart: after the second edge pass=1, fail=0, store_count=2. Reading the FIFO yields (80,3) then (84,7), then rd_valid=0.
- Store 84←5: fail=1 one edge later. A following store 84←7 is ignored (pass stays 0, store_count=1).
- No stores, TIMEOUT=20: timeout=1 after the 20th RUN edge. With a store 84←7 on the 20th cycle, pass=1 and timeout=0.
- DEPTH=8, nine stores to 80 with no reads: overflow=1, store_count=9, exactly 8 entries are readable. Repeat with rd_en held on the ninth cycle: overflow stays 0.
- In the PASS state, pulse clear together with a store 84←7: state returns to RUN, pass=0, store_count=0, FIFO empty, the store is not logged.
- Drop reset low mid-FIFO-fill: all outputs go to their reset values without waiting for a clock. After release, 84←7 gives pass=1.
